m68k_bus_arbiter: RTL and testbench

M68K_BUS_ARBITER -- requirements
Module: m68k_bus_arbiter

---
 rtl/m68k_pkg.sv | 33 +++
 rtl/m68k_bus_arbiter_if.sv | 23 ++
 rtl/m68k_tenure_timer.sv | 30 +++
 rtl/m68k_bus_arbiter.sv | 100 ++++++++++
 tb/tb_m68k_bus_arbiter.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/m68k_pkg.sv
// Shared types and constants for the 68000 bus arbiter: FSM encoding,
// master indices, default tenure limit and the round-robin pick.
package m68k_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        REQUEST  = 3'd1,
        WAIT_BUS = 3'd2,
        OWNED    = 3'd3,
        RELEASE  = 3'd4
    } arb_state_e;

    localparam logic MASTER0 = 1'b0;
    localparam logic MASTER1 = 1'b1;

    localparam int unsigned DEFAULT_MAX_TENURE = 255;

    // A lone requester wins outright; a tie goes to whoever did not own the bus last.
    function automatic logic pick_master(input logic [1:0] req, input logic last_grant);
        logic winner;
        case (req)
            2'b01:   winner = MASTER0;
            2'b10:   winner = MASTER1;
            default: winner = ~last_grant;
        endcase
        return winner;
    endfunction

    function automatic logic [1:0] master_onehot(input logic idx);
        return (idx == MASTER1) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/m68k_bus_arbiter_if.sv
// DMA-side handshake and 68000 control strobes seen by the bus arbiter.
// bgack_n is a shared open-drain line and stays a plain inout on the arbiter.
interface m68k_bus_arbiter_if;

    logic [1:0] req;
    logic [1:0] grant;
    logic       preempt;
    logic       br_n;
    logic       bg_n;
    logic       as_n;
    logic       dtack_n;

    modport master (
        input  req, bg_n, as_n, dtack_n,
        output grant, preempt, br_n
    );

    modport slave (
        output req, bg_n, as_n, dtack_n,
        input  grant, preempt, br_n
    );

endinterface

// File: rtl/m68k_tenure_timer.sv
// Saturating tenure counter: clear wins over enable, holds at MAX and flags it.
module m68k_tenure_timer
    import m68k_pkg::*;
#(
    parameter int unsigned MAX = DEFAULT_MAX_TENURE
) (
    input  logic clk16,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned     W     = $clog2(MAX + 1);
    localparam logic [W-1:0]    LIMIT = W'(MAX);

    logic [W-1:0] count;

    // NOTE: reset is synchronous here -- it is only seen on a clk16 edge, like any other input.
    always_ff @(posedge clk16) begin
        if (!reset_n || clear) begin
            count <= '0;
        end else if (enable && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/m68k_bus_arbiter.sv
// Two-master DMA arbiter for the 68000 bus: round-robin pick, BR/BG/BGACK
// handshake, bounded tenure with preemption and a one-cycle turnaround.
module m68k_bus_arbiter
    import m68k_pkg::*;
#(
    parameter int unsigned MAX_TENURE  = DEFAULT_MAX_TENURE,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk16,
    input  logic                 reset_n,
    m68k_bus_arbiter_if.master   bus,
    inout  wire                  bgack_n
);

    arb_state_e state, state_next;
    logic       sel, sel_next;
    logic       last_grant, last_grant_next;
    logic       expired;
    logic       bus_free;

    logic [SYNC_STAGES-1:0] bg_sync;

    always_ff @(posedge clk16) begin
        if (!reset_n) begin
            bg_sync <= '1;
        end else begin
            bg_sync <= {bg_sync[SYNC_STAGES-2:0], bus.bg_n};
        end
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk16) begin
        if (!reset_n) begin
            state      <= IDLE;
            sel        <= MASTER0;
            last_grant <= MASTER1;
        end else begin
            state      <= state_next;
            sel        <= sel_next;
            last_grant <= last_grant_next;
        end
    end

    // CPU has granted and the previous owner has fully left the bus.
    assign bus_free = !bg_sync[SYNC_STAGES-1] && bus.as_n && bus.dtack_n && (bgack_n == 1'b1);

    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        state_next      = state;
        sel_next        = sel;
        last_grant_next = last_grant;
        case (state)
            IDLE: begin
                if (|bus.req) begin
                    sel_next   = pick_master(bus.req, last_grant);
                    state_next = REQUEST;
                end
            end
            REQUEST: begin
                state_next = bus.req[sel] ? WAIT_BUS : IDLE;
            end
            WAIT_BUS: begin
                if (!bus.req[sel]) begin
                    state_next = IDLE;
                end else if (bus_free) begin
                    state_next      = OWNED;
                    last_grant_next = sel;
                end
            end
            OWNED: begin
                if (!bus.req[sel] || (expired && bus.as_n)) begin
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Counter is held clear outside OWNED, so it reads zero on the first owned cycle.
    m68k_tenure_timer #(
        .MAX (MAX_TENURE)
    ) u_tenure (
        .clk16   (clk16),
        .reset_n (reset_n),
        .clear   (state != OWNED),
        .enable  (state == OWNED),
        .expired (expired)
    );

    assign bus.grant   = (state == OWNED) ? master_onehot(sel) : 2'b00;
    assign bus.preempt = (state == OWNED) && expired;
    assign bus.br_n    = !((state == REQUEST) || (state == WAIT_BUS));
    assign bgack_n     = (state == OWNED) ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_m68k_bus_arbiter.sv
// Directed bench for m68k_bus_arbiter: handshake, round-robin, preemption,
// bus-busy qualification, request withdrawal and reset mid-tenure.
module tb_m68k_bus_arbiter;
    import m68k_pkg::*;

    logic clk16   = 1'b0;
    logic reset_n = 1'b0;
    wire  bgack_n;
    pullup (bgack_n);

    m68k_bus_arbiter_if bus();

    m68k_bus_arbiter #(
        .MAX_TENURE  (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk16   (clk16),
        .reset_n (reset_n),
        .bus     (bus),
        .bgack_n (bgack_n)
    );

    always #5 clk16 = ~clk16;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic overlap_seen = 1'b0;

    always @(negedge clk16) begin
        if (!$onehot0(bus.grant)) overlap_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk16);
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        bus.req     = 2'b00;
        bus.bg_n    = 1'b1;
        bus.as_n    = 1'b1;
        bus.dtack_n = 1'b1;
        tick(2);
        reset_n = 1'b1;
    endtask

    task automatic wait_br_low(input string tag);
        int n = 0;
        while (bus.br_n !== 1'b0 && n < 10) begin
            tick(1);
            n++;
        end
        check({tag, "_br_low"}, 32'(bus.br_n), 32'd0);
    endtask

    task automatic wait_grant(input string tag, input logic [1:0] exp);
        int n = 0;
        while (bus.grant === 2'b00 && n < 10) begin
            tick(1);
            n++;
        end
        check({tag, "_grant"}, 32'(bus.grant), 32'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [1:0] order [4];
        order[0] = 2'b01; order[1] = 2'b10; order[2] = 2'b01; order[3] = 2'b10;

        // Reset state
        do_reset();
        reset_n = 1'b0;
        tick(1);
        check("rst_grant",   32'(bus.grant),   32'd0);
        check("rst_br_n",    32'(bus.br_n),    32'd1);
        check("rst_bgack_n", 32'(bgack_n),     32'd1);
        check("rst_preempt", 32'(bus.preempt), 32'd0);
        check("rst_state",   32'(dut.state),   32'(IDLE));
        reset_n = 1'b1;

        // Basic handshake, CPU grants 3 cycles after br_n falls
        bus.req = 2'b01;
        tick(1);
        check("t1_br_n_1cyc", 32'(bus.br_n), 32'd0);
        tick(3);
        check("t1_no_grant_pre_bg", 32'(bus.grant), 32'd0);
        bus.bg_n = 1'b0;
        tick(2);
        check("t1_no_grant_sync", 32'(bus.grant), 32'd0);
        tick(1);
        check("t1_grant",   32'(bus.grant), 32'(2'b01));
        check("t1_bgack_n", 32'(bgack_n),   32'd0);
        check("t1_br_n_hi", 32'(bus.br_n),  32'd1);
        bus.bg_n = 1'b1;
        tick(3);
        check("t1_grant_hold", 32'(bus.grant), 32'(2'b01));
        bus.req = 2'b00;
        tick(1);
        check("t1_rel_state", 32'(dut.state), 32'(RELEASE));
        check("t1_rel_grant", 32'(bus.grant), 32'd0);
        check("t1_rel_bgack", 32'(bgack_n),   32'd1);
        check("t1_rel_br_n",  32'(bus.br_n),  32'd1);
        tick(1);
        check("t1_idle", 32'(dut.state), 32'(IDLE));

        // Round-robin with both masters requesting continuously
        do_reset();
        bus.req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            wait_br_low($sformatf("rr%0d", i));
            bus.bg_n = 1'b0;
            wait_grant($sformatf("rr%0d", i), order[i]);
            bus.bg_n = 1'b1;
            tick(5);
            check($sformatf("rr%0d_hold", i), 32'(bus.grant), 32'(order[i]));
            bus.req = 2'b11 & ~order[i];
            tick(1);
            check($sformatf("rr%0d_rel", i), 32'(bus.grant), 32'd0);
            bus.req = 2'b11;
        end
        bus.req = 2'b00;
        tick(3);

        // Preemption at tenure count 8, deferred while as_n is low
        do_reset();
        bus.req = 2'b01;
        wait_br_low("pre");
        bus.bg_n = 1'b0;
        wait_grant("pre", 2'b01);
        bus.bg_n = 1'b0;
        bus.as_n = 1'b0;
        bus.bg_n = 1'b1;
        tick(7);
        check("pre_cnt7_preempt", 32'(bus.preempt), 32'd0);
        tick(1);
        check("pre_cnt8_preempt", 32'(bus.preempt), 32'd1);
        tick(2);
        check("pre_as_low_grant",   32'(bus.grant),   32'(2'b01));
        check("pre_as_low_preempt", 32'(bus.preempt), 32'd1);
        bus.as_n = 1'b1;
        tick(1);
        check("pre_rel_state",   32'(dut.state),   32'(RELEASE));
        check("pre_rel_grant",   32'(bus.grant),   32'd0);
        check("pre_rel_preempt", 32'(bus.preempt), 32'd0);
        bus.req = 2'b00;
        tick(1);
        check("pre_idle", 32'(dut.state), 32'(IDLE));

        // Bus still busy: bg_n granted but as_n, then dtack_n, held low
        do_reset();
        bus.req = 2'b10;
        wait_br_low("busy");
        bus.as_n = 1'b0;
        bus.bg_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check($sformatf("busy_as_low%0d", i), 32'(bus.grant), 32'd0);
        end
        bus.as_n    = 1'b1;
        bus.dtack_n = 1'b0;
        tick(1);
        check("busy_dtack_low", 32'(bus.grant), 32'd0);
        bus.dtack_n = 1'b1;
        tick(1);
        check("busy_grant", 32'(bus.grant), 32'(2'b10));
        bus.bg_n = 1'b1;
        bus.req  = 2'b00;
        tick(2);

        // Request withdrawn in WAIT_BUS, then in REQUEST
        do_reset();
        bus.req = 2'b01;
        tick(2);
        check("wd_wait_state", 32'(dut.state), 32'(WAIT_BUS));
        bus.req = 2'b00;
        tick(1);
        check("wd_wait_br_n",  32'(bus.br_n),  32'd1);
        check("wd_wait_grant", 32'(bus.grant), 32'd0);
        check("wd_wait_idle",  32'(dut.state), 32'(IDLE));
        bus.req = 2'b10;
        tick(1);
        bus.req = 2'b00;
        tick(1);
        check("wd_req_idle", 32'(dut.state), 32'(IDLE));
        check("wd_req_br_n", 32'(bus.br_n),  32'd1);

        // Reset asserted mid-tenure with preempt already raised
        do_reset();
        bus.req = 2'b01;
        wait_br_low("mid");
        bus.bg_n = 1'b0;
        wait_grant("mid", 2'b01);
        bus.bg_n = 1'b1;
        bus.as_n = 1'b0;
        tick(8);
        check("mid_preempt_set", 32'(bus.preempt), 32'd1);
        reset_n = 1'b0;
        tick(1);
        check("mid_grant",   32'(bus.grant),   32'd0);
        check("mid_br_n",    32'(bus.br_n),    32'd1);
        check("mid_bgack_n", 32'(bgack_n),     32'd1);
        check("mid_preempt", 32'(bus.preempt), 32'd0);
        check("mid_state",   32'(dut.state),   32'(IDLE));
        reset_n  = 1'b1;
        bus.req  = 2'b00;
        bus.as_n = 1'b1;
        tick(2);

        check("grant_onehot", 32'(overlap_seen), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
